cmp_iter: RTL and testbench



---
 rtl/cmp_iter.sv | 209 ++++++++++++++++++++
 tb/tb_cmp_iter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_iter.sv
// -----------------------------------------------------------------------------
// cmp_iter: multi-cycle, chunk-serial branch/compare unit.
//
// Evaluates EQ, NE, LT, LTU, GE, GEU on WIDTH-bit operands by scanning CHUNK
// bits per cycle from the most significant chunk downward. The scan stops at
// the first chunk that differs, so the latency depends on the data.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  unit is idle and can accept a request
//   a, b       in   WIDTH-bit operands
//   ctrl       in   001 EQ, 010 NE, 011 LT, 100 LTU, 101 GE, 110 GEU
//                   (000 and 111 are invalid and return all-zero results)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts the result
//   c          out  relation result
//   eq         out  a == b
//   lt         out  a < b (signed for LT/GE, unsigned otherwise)
//
// WIDTH must be an integer multiple of CHUNK.
// -----------------------------------------------------------------------------
module cmp_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             c,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

    localparam logic [2:0] OP_EQ  = 3'b001;
    localparam logic [2:0] OP_NE  = 3'b010;
    localparam logic [2:0] OP_LT  = 3'b011;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_GEU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [2:0]       ctrl_reg, ctrl_next;
    logic [KW-1:0]    k_reg, k_next;
    logic             c_reg, c_next;
    logic             eq_reg, eq_next;
    logic             lt_reg, lt_next;

    // Latched operands split into chunks; chunk 0 is the least significant.
    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic [CHUNK-1:0] cur_a, cur_b;
    logic             signed_op;
    logic             ctrl_ok;
    logic             chunk_diff;
    logic             chunk_lt;

    assign signed_op = (ctrl_reg == OP_LT) || (ctrl_reg == OP_GE);
    assign ctrl_ok   = (ctrl != 3'b000) && (ctrl != 3'b111);

    // Map the final (eq, lt) pair onto the requested relation.
    function automatic logic relation(input logic [2:0] op, input logic e, input logic l);
        logic r;
        case (op)
            OP_EQ:          r = e;
            OP_NE:          r = ~e;
            OP_LT, OP_LTU:  r = l;
            OP_GE, OP_GEU:  r = ~l;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // Chunk select and signed bias. Flipping the sign bit of the top chunk
    // turns a two's-complement compare into an unsigned one; lower chunks
    // carry magnitude bits only and are compared unbiased.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_reg == KW'(i)) begin
                cur_a = a_chunk[i];
                cur_b = b_chunk[i];
            end
        end
        if (signed_op && (k_reg == K_TOP)) begin
            cur_a[CHUNK-1] = ~cur_a[CHUNK-1];
            cur_b[CHUNK-1] = ~cur_b[CHUNK-1];
        end
        chunk_diff = (cur_a != cur_b);
        chunk_lt   = (cur_a < cur_b);
    end

    // Next-state and datapath update.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        ctrl_next  = ctrl_reg;
        k_next     = k_reg;
        c_next     = c_reg;
        eq_next    = eq_reg;
        lt_next    = lt_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next    = a;
                    b_next    = b;
                    ctrl_next = ctrl;
                    k_next    = K_TOP;
                    if (ctrl_ok) begin
                        state_next = SCAN;
                    end else begin
                        // Invalid opcode: skip the scan and report all zeros.
                        state_next = DONE;
                        c_next     = 1'b0;
                        eq_next    = 1'b0;
                        lt_next    = 1'b0;
                    end
                end
            end

            SCAN: begin
                if (chunk_diff) begin
                    state_next = DONE;
                    eq_next    = 1'b0;
                    lt_next    = chunk_lt;
                    c_next     = relation(ctrl_reg, 1'b0, chunk_lt);
                end else if (k_reg == '0) begin
                    state_next = DONE;
                    eq_next    = 1'b1;
                    lt_next    = 1'b0;
                    c_next     = relation(ctrl_reg, 1'b1, 1'b0);
                end else begin
                    k_next = k_reg - 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            ctrl_reg  <= '0;
            k_reg     <= '0;
            c_reg     <= 1'b0;
            eq_reg    <= 1'b0;
            lt_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            ctrl_reg  <= ctrl_next;
            k_reg     <= k_next;
            c_reg     <= c_next;
            eq_reg    <= eq_next;
            lt_reg    <= lt_next;
        end
    end

    // in_ready is gated by rst_n so it drops the instant reset asserts.
    assign in_ready  = (state_reg == IDLE) && rst_n;
    assign out_valid = (state_reg == DONE);
    assign c         = c_reg;
    assign eq        = eq_reg;
    assign lt        = lt_reg;

endmodule

// File: tb/tb_cmp_iter.sv
// -----------------------------------------------------------------------------
// Testbench for cmp_iter. Two instances: WIDTH=32/CHUNK=8 and WIDTH=CHUNK=16.
// The driver pushes the expected result of each accepted request into a
// per-instance queue; monitors pop and compare when out_valid rises and keep
// comparing while the result is held.
// -----------------------------------------------------------------------------
module tb_cmp_iter;

    typedef struct {
        logic   c;
        logic   eq;
        logic   lt;
        longint t_acc;
        int     p;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, c, eq, lt;
    logic [31:0] a, b;
    logic [2:0]  ctrl;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, c16, eq16, lt16;
    logic [15:0] a16, b16;
    logic [2:0]  ctrl16;

    int     errors = 0;
    int     checks = 0;
    exp_t   q32[$];
    exp_t   q16[$];
    exp_t   cur[2];
    logic   cur_ok[2];
    logic   prev_v[2];
    longint last_acc[2];
    longint hs32 = 0;
    int     rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

    cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctrl(ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .eq(eq), .lt(lt)
    );

    cmp_iter #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .ctrl(ctrl16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .c(c16), .eq(eq16), .lt(lt16)
    );

    assign out_ready16 = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs32 = $time;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input int ch, input logic [31:0] av,
                                   input logic [31:0] bv, input logic [2:0] cv);
        exp_t   e;
        longint one = 1;
        longint full = (one << w) - 1;
        longint mask = (one << ch) - 1;
        longint ua = longint'(av) & full;
        longint ub = longint'(bv) & full;
        longint sa = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
        longint sb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        int     n = w / ch;
        e.eq = (ua == ub);
        e.lt = (cv == 3'd3 || cv == 3'd5) ? (sa < sb) : (ua < ub);
        e.p  = n;
        for (int i = n - 1; i >= 0; i--) begin
            if (((ua >> (i * ch)) & mask) != ((ub >> (i * ch)) & mask)) begin
                e.p = n - i;
                break;
            end
        end
        case (cv)
            3'd1:       e.c = e.eq;
            3'd2:       e.c = !e.eq;
            3'd3, 3'd4: e.c = e.lt;
            3'd5, 3'd6: e.c = !e.lt;
            default: begin
                e.c = 0; e.eq = 0; e.lt = 0; e.p = 0;
            end
        endcase
        e.t_acc = 0;
        return e;
    endfunction

    // Present one request and wait (bounded) for it to be accepted.
    task automatic issue(input int which, input logic [31:0] av, input logic [31:0] bv,
                         input logic [2:0] cv);
        exp_t e;
        int   tmo = 0;
        @(negedge clk);
        if (which == 0) begin
            a = av; b = bv; ctrl = cv; in_valid = 1'b1;
        end else begin
            a16 = av[15:0]; b16 = bv[15:0]; ctrl16 = cv; in_valid16 = 1'b1;
        end
        while (!(which == 0 ? in_ready : in_ready16)) begin
            @(negedge clk);
            tmo++;
            if (tmo > 300) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0; in_valid16 = 1'b0;
                return;
            end
        end
        @(posedge clk);
        e = (which == 0) ? model(32, 8, av, bv, cv) : model(16, 16, av, bv, cv);
        e.t_acc = $time;
        last_acc[which] = $time;
        if (which == 0) q32.push_back(e); else q16.push_back(e);
        $display("issue dut%0d a=%h b=%h ctrl=%0d -> c=%0d eq=%0d lt=%0d p=%0d",
                 which == 0 ? 32 : 16, av, bv, cv, e.c, e.eq, e.lt, e.p);
        #1;
        // Scramble inputs after acceptance; they must not influence the result.
        if (which == 0) begin
            in_valid = 1'b0; a = $urandom; b = $urandom; ctrl = 3'($urandom);
        end else begin
            in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); ctrl16 = 3'($urandom);
        end
    endtask

    task automatic mon(input int which);
        logic  v, cc, ee, ll, ir;
        string tag;
        tag = (which == 0) ? "dut32" : "dut16";
        if (which == 0) begin
            v = out_valid; cc = c; ee = eq; ll = lt; ir = in_ready;
        end else begin
            v = out_valid16; cc = c16; ee = eq16; ll = lt16; ir = in_ready16;
        end
        if (!rst_n) begin
            prev_v[which] = 1'b0;
            return;
        end
        if (v) begin
            if (!prev_v[which]) begin
                if ((which == 0 ? q32.size() : q16.size()) == 0) begin
                    chk({tag, "_unexpected_result"}, 1, 0);
                    cur_ok[which] = 1'b0;
                end else begin
                    cur[which] = (which == 0) ? q32.pop_front() : q16.pop_front();
                    cur_ok[which] = 1'b1;
                    chk({tag, "_latency"}, ($time - 5 - cur[which].t_acc) / 10, cur[which].p);
                    $display("result %s c=%0d eq=%0d lt=%0d", tag, cc, ee, ll);
                end
            end
            if (cur_ok[which]) begin
                chk({tag, "_c"}, cc, cur[which].c);
                chk({tag, "_eq"}, ee, cur[which].eq);
                chk({tag, "_lt"}, ll, cur[which].lt);
            end
            chk({tag, "_in_ready_busy"}, ir, 0);
        end
        prev_v[which] = v;
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0 || out_valid || out_valid16) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 400, 1);
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        prev_v[0] = 0; prev_v[1] = 0; cur_ok[0] = 0; cur_ok[1] = 0;
        in_valid = 0; a = 0; b = 0; ctrl = 0;
        in_valid16 = 0; a16 = 0; b16 = 0; ctrl16 = 0;
        rst_n = 0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c_eq_lt", {c, eq, lt}, 0);
        chk("rst_in_ready16", in_ready16, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("in_ready_after_release", in_ready, 1);

        // Directed vectors.
        issue(0, 32'h12345678, 32'h12345678, 3'd1);
        issue(0, 32'h12345678, 32'h12345678, 3'd2);
        issue(0, 32'h80000000, 32'h00000001, 3'd3);
        issue(0, 32'h80000000, 32'h00000001, 3'd4);
        issue(0, 32'h80000000, 32'h00000001, 3'd6);
        issue(0, 32'h000000FF, 32'h000000FE, 3'd6);
        issue(0, 32'h000000FE, 32'h000000FF, 3'd6);
        issue(0, 32'hDEADBEEF, 32'h01234567, 3'd7);
        issue(0, 32'hDEADBEEF, 32'hDEADBEEF, 3'd0);
        drain();

        // Backpressure: result held while a new request waits.
        rdy_mode = 0;
        issue(0, 32'h000000FF, 32'h000000FE, 3'd6);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_wait_valid", n < 100, 1);
        fork
            begin repeat (5) @(negedge clk); rdy_mode = 1; end
            issue(0, 32'h80000000, 32'h00000001, 3'd3);
        join
        chk("bp_accept_after_hs", (last_acc[0] - hs32) / 10, 1);
        drain();

        // Asynchronous reset in the 2nd SCAN cycle; prior result has c=eq=1.
        issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1);
        drain();
        issue(0, 32'hFFFFFFFF, 32'hFFFFFFFE, 3'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_c", c, 0);
        chk("async_rst_eq", eq, 0);
        chk("async_rst_in_ready", in_ready, 0);
        q32.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        chk("in_ready_after_rerelease", in_ready, 1);
        repeat (6) @(negedge clk);
        chk("no_partial_result", out_valid, 0);
        issue(0, 32'hFFFFFFFB, 32'h00000003, 3'd5);
        drain();

        // Single-pass instance.
        issue(1, 32'h00008000, 32'h00007FFF, 3'd3);
        issue(1, 32'h00008000, 32'h00007FFF, 3'd4);
        issue(1, 32'h0000ABCD, 32'h0000ABCD, 3'd1);
        for (int i = 0; i < 20; i++) issue(1, $urandom, $urandom, 3'($urandom));
        drain();

        // Randomised phase with random consumer backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
                2:       rb = ra ^ 32'($urandom_range(1, 3));
                default: rb = $urandom;
            endcase
            issue(0, ra, rb, 3'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rdy_mode = 1;
        drain();
        chk("q32_empty", q32.size(), 0);
        chk("q16_empty", q16.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
